universal_shift_register_burst: RTL and testbench
=================================================

Name: universal_shift_register_burst

Overview:
- Parametrised universal shift register and the next generation of the team's serial/parallel shift-register-with-load block.
- Adds bidirectional shift, rotate, arithmetic shift, clear and hold modes, plus a counted burst engine.
- The burst engine performs a programmed number of consecutive shifts autonomously, with busy/done handshake.
- Used as a configurable serializer/deserializer and barrel-shift-by-iteration element in datapaths.

Parameters:
- N, 8, register width in bits (N >= 2).
- CW, 4, width of the burst count port; 2^CW - 1 >= N required.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  enables the single-cycle operation selected by mode while IDLE.
- mode  input  3  operation select, encoding below.
- I  input  N  parallel load data.
- SI_R  input  1  serial input for right shift; enters at Q[N-1].
- SI_L  input  1  serial input for left shift; enters at Q[0].
- start  input  1  one-cycle request to begin a burst.
- count  input  CW  number of shifts in a burst.
- Q  output  N  register contents.
- SO_R  output  1  Q[0]; bit leaving on a right shift.
- SO_L  output  1  Q[N-1]; bit leaving on a left shift.
- busy  output  1  high while a burst is in progress (state BURST).
- done  output  1  one-cycle pulse after the last shift of a burst.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset is sampled only on a rising clk edge and has priority over all other inputs.
- Reset state: Q=0, state=IDLE, remaining-count=0, busy=0, done=0.
- Reset asserted mid-burst aborts the burst immediately; no done pulse is produced.
- Mode encoding, per edge:
  - 000 hold.
  - 001 shift right: Q <= {SI_R, Q[N-1:1]}.
  - 010 shift left: Q <= {Q[N-2:0], SI_L}.
  - 011 rotate right: {Q[0], Q[N-1:1]}.
  - 100 rotate left: {Q[N-2:0], Q[N-1]}.
  - 101 parallel load: Q <= I.
  - 110 arithmetic shift right: {Q[N-1], Q[N-1:1]}.
  - 111 clear: Q <= 0.
- Shift modes are 001, 010, 011, 100 and 110.
- Serial inputs and I are sampled on the edge where the operation occurs.
- SO_R and SO_L are combinational from Q and carry no extra latency.
- IDLE, no valid start: if en=1, apply mode once; if en=0, hold Q.
- Valid start (IDLE only) requires start=1, count!=0 and mode is a shift mode. On that edge:
  - Latch mode; en is ignored.
  - Perform the first shift.
  - Load remaining-count <= count-1.
  - If count==1: stay IDLE and set done<=1.
  - Otherwise go to BURST.
- BURST, each edge:
  - Perform one shift using the latched mode; serial inputs are sampled live.
  - Decrement remaining-count.
  - When remaining-count==1 at the edge: perform the final shift, go to IDLE, set done<=1.
- Burst timing: exactly count shifts on count consecutive edges, starting with the start edge.
- busy is high for count-1 cycles, i.e. only in BURST.
- done is high for exactly one cycle: the first IDLE cycle after the last shift.
- done is cleared on the next edge unless a new count==1 burst restarts it.
- In BURST, start, en, mode, count and I are ignored. A burst cannot be reloaded or cleared except by reset.
- start with count==0: no shift, no state change, no done pulse. The edge behaves as an ordinary IDLE edge (en/mode apply).
- start with a non-shift mode (000, 101, 111): no burst. The edge behaves as an ordinary IDLE edge.
- start in the same cycle that done is high is legal; a new burst begins back-to-back.
- count > N is legal; rotates wrap and shifts fully flush in serial input values.

Test Plan:
- N=8. reset=1 for 2 edges with I=8'hFF, mode=101, en=1 -> Q=8'h00, busy=0, done=0. Release reset, load 8'hA5 -> Q=8'hA5 after 1 edge.
- Q=8'hA5, en=1, cycle modes in order:
  - 001, SI_R=1 -> Q=8'hD2.
  - 010, SI_L=0 -> Q=8'hA4.
  - 011 -> Q=8'h52.
  - 100 -> Q=8'hA4.
  - 110 -> Q=8'hD2.
  - 111 -> Q=8'h00.
  - 000 with en=0 -> Q held.
- Q=8'h81, start=1, mode=011, count=3, then start=0 with mode/en toggled randomly:
  - Q=8'hC0, 8'h60, 8'h30 on 3 consecutive edges.
  - busy high for 2 cycles.
  - done high for 1 cycle after the third edge.
  - Random mode/en toggling has no effect.
- start with count=0 and mode=001, en=0 -> Q unchanged, busy=0, done=0. Then start with count=1, mode=010, SI_L=1 on Q=8'h01 -> Q=8'h03, busy stays 0, done pulses once.
- Burst mode=001, count=6, Q=8'hFF, SI_R=0; assert reset on the third burst edge -> Q=8'h00 next cycle, busy=0, no done pulse ever. A subsequent en=1, mode=101, I=8'h3C -> Q=8'h3C.
- Back-to-back bursts: re-issue start in the done cycle with mode=100, count=2, Q=8'h01:
  - Second burst begins on that edge.
  - Q=8'h02, then 8'h04.
  - busy high 1 cycle.
  - done pulses again.

Source files
------------

// File: rtl/universal_shift_register_burst_if.sv
// Purpose: bundles the control, data and status signals of universal_shift_register_burst.
// Ports: en/mode/I/SI_R/SI_L/start/count flow master->slave; Q/SO_R/SO_L/busy/done flow slave->master.
// Latency/backpressure: none here; the slave updates Q one edge after an operation is requested.
interface universal_shift_register_burst_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          en;
  logic [2:0]    mode;
  logic [N-1:0]  I;
  logic          SI_R;
  logic          SI_L;
  logic          start;
  logic [CW-1:0] count;
  logic [N-1:0]  Q;
  logic          SO_R;
  logic          SO_L;
  logic          busy;
  logic          done;

  modport master (
    output en, mode, I, SI_R, SI_L, start, count,
    input  Q, SO_R, SO_L, busy, done
  );

  modport slave (
    input  en, mode, I, SI_R, SI_L, start, count,
    output Q, SO_R, SO_L, busy, done
  );
endinterface

// File: rtl/universal_shift_register_burst.sv
// Purpose: N-bit universal shift register (hold/shift/rotate/ashift/load/clear) with a counted burst engine.
// Latency: every operation lands in Q one edge after it is requested; SO_R/SO_L are combinational from Q.
// Backpressure: none; while busy all requests except reset are ignored, done pulses one cycle after the last shift.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries en, mode, I, SI_R, SI_L, start, count,
//        Q, SO_R, SO_L, busy, done.
module universal_shift_register_burst #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  universal_shift_register_burst_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t        state;
  logic [N-1:0]  q;
  logic [CW-1:0] remaining;
  logic [2:0]    burst_mode;
  logic          busy_q;
  logic          done_q;

  function automatic logic [N-1:0] next_q(
    input logic [2:0]   m,
    input logic [N-1:0] cur,
    input logic         si_r,
    input logic         si_l,
    input logic [N-1:0] din
  );
    logic [N-1:0] r;
    r = cur;
    case (m)
      M_HOLD: r = cur;
      M_SHR:  r = {si_r, cur[N-1:1]};
      M_SHL:  r = {cur[N-2:0], si_l};
      M_ROR:  r = {cur[0], cur[N-1:1]};
      M_ROL:  r = {cur[N-2:0], cur[N-1]};
      M_LOAD: r = din;
      M_ASR:  r = {cur[N-1], cur[N-1:1]};
      M_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) || (m == M_ROL) || (m == M_ASR);
  endfunction

  logic start_ok;
  assign start_ok = bus.start && (bus.count != '0) && is_shift(bus.mode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      remaining  <= '0;
      burst_mode <= M_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-armed below on this edge.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            // The start edge itself performs the first of the count shifts.
            burst_mode <= bus.mode;
            q          <= next_q(bus.mode, q, bus.SI_R, bus.SI_L, bus.I);
            remaining  <= bus.count - 1'b1;
            if (bus.count == CW'(1)) begin
              done_q <= 1'b1;
            end else begin
              state  <= BURST;
              busy_q <= 1'b1;
            end
          end else if (bus.en) begin
            q <= next_q(bus.mode, q, bus.SI_R, bus.SI_L, bus.I);
          end
        end
        BURST: begin
          // Latched mode drives the shift; serial inputs are still taken live.
          q         <= next_q(burst_mode, q, bus.SI_R, bus.SI_L, bus.I);
          remaining <= remaining - 1'b1;
          if (remaining == CW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.SO_R = q[0];
  assign bus.SO_L = q[N-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Purpose: bench for universal_shift_register_burst: directed vector table, mid-burst reset sequence, random vs model.
// Ports: drives the interface master side; clk generated locally, reset driven from the stimulus.
// Timing: inputs change 1 time unit after a rising edge, outputs are compared at that same point.
module tb_universal_shift_register_burst;
  localparam int N  = 8;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  universal_shift_register_burst_if #(.N(N), .CW(CW)) bus ();

  universal_shift_register_burst #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic [N-1:0]  din;
    logic          sir;
    logic          sil;
    logic          start;
    logic [CW-1:0] cnt;
    logic [N-1:0]  exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic [2:0] mode, input logic [N-1:0] din,
                     input logic sir, input logic sil, input logic start, input logic [CW-1:0] cnt,
                     input logic [N-1:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.din = din; v.sir = sir; v.sil = sil;
    v.start = start; v.cnt = cnt; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] mode, input logic [N-1:0] din,
                       input logic sir, input logic sil, input logic start, input logic [CW-1:0] cnt);
    reset     = rst;
    bus.en    = en;
    bus.mode  = mode;
    bus.I     = din;
    bus.SI_R  = sir;
    bus.SI_L  = sil;
    bus.start = start;
    bus.count = cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] eq, input logic eb, input logic ed);
    chk({tag, "_Q"},    32'(bus.Q),    32'(eq));
    chk({tag, "_SO_R"}, 32'(bus.SO_R), 32'(eq[0]));
    chk({tag, "_SO_L"}, 32'(bus.SO_L), 32'(eq[N-1]));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(eb));
    chk({tag, "_done"}, 32'(bus.done), 32'(ed));
  endtask

  // Reference model: tracks how many burst shifts are still owed rather than an FSM.
  logic [N-1:0] m_q;
  int           m_left;
  logic [2:0]   m_bmode;
  logic         m_done;

  function automatic logic [N-1:0] ref_op(input logic [2:0] m, input logic [N-1:0] q,
                                         input logic sir, input logic sil, input logic [N-1:0] din);
    logic [N-1:0] r;
    case (m)
      3'd1: r = (q >> 1) | (N'(sir) << (N-1));
      3'd2: r = (q << 1) | N'(sil);
      3'd3: r = (q >> 1) | (N'(q[0]) << (N-1));
      3'd4: r = (q << 1) | (q >> (N-1));
      3'd5: r = din;
      3'd6: r = $signed(q) >>> 1;
      3'd7: r = '0;
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic logic ref_is_shift(input logic [2:0] m);
    return m inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_q = '0; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_q    = ref_op(m_bmode, m_q, bus.SI_R, bus.SI_L, bus.I);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (bus.start && bus.count != 0 && ref_is_shift(bus.mode)) begin
      m_bmode = bus.mode;
      m_q     = ref_op(bus.mode, m_q, bus.SI_R, bus.SI_L, bus.I);
      m_left  = int'(bus.count) - 1;
      m_done  = (m_left == 0);
    end else begin
      if (bus.en) m_q = ref_op(bus.mode, m_q, bus.SI_R, bus.SI_L, bus.I);
      m_done = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_q = '0; m_left = 0; m_bmode = 3'd0; m_done = 1'b0;
    drive(1, 0, 3'd0, '0, 0, 0, 0, '0);

    //   rst en mode din    sir sil st cnt   Q      busy done
    add(1, 1, 3'd5, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add(1, 1, 3'd5, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add(0, 1, 3'd5, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add(0, 1, 3'd1, 8'h00, 1, 0, 0, 4'd0, 8'hD2, 0, 0);
    add(0, 1, 3'd2, 8'h00, 0, 0, 0, 4'd0, 8'hA4, 0, 0);
    add(0, 1, 3'd3, 8'h00, 0, 0, 0, 4'd0, 8'h52, 0, 0);
    add(0, 1, 3'd4, 8'h00, 0, 0, 0, 4'd0, 8'hA4, 0, 0);
    add(0, 1, 3'd6, 8'h00, 0, 0, 0, 4'd0, 8'hD2, 0, 0);
    add(0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add(0, 1, 3'd5, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    add(0, 0, 3'd7, 8'h00, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    // rotate-right burst of 3; later edges try to disturb it
    add(0, 0, 3'd3, 8'h00, 0, 0, 1, 4'd3, 8'hC0, 1, 0);
    add(0, 1, 3'd7, 8'h00, 1, 1, 1, 4'd5, 8'h60, 1, 0);
    add(0, 1, 3'd5, 8'hFF, 0, 0, 0, 4'd0, 8'h30, 0, 1);
    add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h30, 0, 0);
    // count==0 and non-shift starts act as plain IDLE edges
    add(0, 0, 3'd1, 8'h00, 1, 0, 1, 4'd0, 8'h30, 0, 0);
    add(0, 1, 3'd5, 8'h11, 0, 0, 1, 4'd0, 8'h11, 0, 0);
    add(0, 1, 3'd7, 8'h00, 0, 0, 1, 4'd3, 8'h00, 0, 0);
    add(0, 1, 3'd5, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    // single-shift burst
    add(0, 0, 3'd2, 8'h00, 0, 1, 1, 4'd1, 8'h03, 0, 1);
    add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0);
    // back-to-back: second start issued while done is high
    add(0, 1, 3'd5, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0);
    add(0, 0, 3'd4, 8'h00, 0, 0, 1, 4'd1, 8'h01, 0, 1);
    add(0, 0, 3'd4, 8'h00, 0, 0, 1, 4'd2, 8'h02, 1, 0);
    add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h04, 0, 1);
    add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h04, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].mode, vecs[k].din,
            vecs[k].sir, vecs[k].sil, vecs[k].start, vecs[k].cnt);
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].exp_q, vecs[k].exp_busy, vecs[k].exp_done);
    end

    // Reset on the third edge of a 6-shift burst aborts it with no done pulse.
    drive(0, 1, 3'd5, 8'hFF, 0, 0, 0, 4'd0); tick(); chk_all("abort_load", 8'hFF, 0, 0);
    drive(0, 0, 3'd1, 8'h00, 0, 0, 1, 4'd6); tick(); chk_all("abort_e1", 8'h7F, 1, 0);
    drive(0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd0); tick(); chk_all("abort_e2", 8'h3F, 1, 0);
    drive(1, 0, 3'd1, 8'h00, 0, 0, 0, 4'd0); tick(); chk_all("abort_rst", 8'h00, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0); tick();
      chk_all($sformatf("abort_quiet%0d", c), 8'h00, 0, 0);
    end
    drive(0, 1, 3'd5, 8'h3C, 0, 0, 0, 4'd0); tick(); chk_all("abort_reload", 8'h3C, 0, 0);

    // Random stimulus against the reference model, starting from reset.
    for (int c = 0; c < 800; c++) begin
      drive((c == 0) || ($urandom_range(39) == 0),
            1'($urandom), 3'($urandom), N'($urandom),
            1'($urandom), 1'($urandom),
            $urandom_range(3) == 0, CW'($urandom));
      model_edge();
      tick();
      chk_all($sformatf("rnd%0d", c), m_q, m_left > 0, m_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
